// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled SPI responder.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE,
        WAIT
    } state_t;

    localparam int CPOL       = 1;
    localparam int CPHA       = 0;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
import spi_pkg::*;

module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {SYNC_DEPTH{RST_VAL}};
        end else begin
            ff <= {ff[SYNC_DEPTH-2:0], d};
        end
    end

    assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/ss_n/mosi in the clk domain and
// exchanges one DW-bit word per frame with local logic.
import spi_pkg::*;

module spi_slave #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    spi_mode,
    input  logic          sclk,
    input  logic          ss_n,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          tx_underrun,
    output logic          frame_err
);

    localparam int CW = $clog2(DW + 1);

    logic ss_s, sclk_s, mosi_s;
    logic ss_q, sclk_q;

    spi_sync #(.RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d(ss_n), .q(ss_s)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
    );

    state_t        state, state_nx;
    logic          cpol, cpha;
    logic [DW-1:0] hold;
    logic          hold_full;
    logic [DW-1:0] tx_sh;
    logic [DW-1:0] rx_sh;
    logic [CW-1:0] cnt;
    logic          miso_r;

    logic ss_fall, ss_rise, sclk_chg;
    logic lead, trail, sample, shift;
    logic start, abort, do_sample, do_shift, finish;

    assign ss_fall  = ss_q & ~ss_s;
    assign ss_rise  = ~ss_q & ss_s;
    assign sclk_chg = sclk_s ^ sclk_q;
    assign lead     = sclk_chg & (sclk_q == cpol);
    assign trail    = sclk_chg & (sclk_s == cpol);
    // CPHA swaps which edge samples mosi and which advances miso
    assign sample   = cpha ? trail : lead;
    assign shift    = cpha ? lead : trail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ss_q   <= 1'b1;
            sclk_q <= 1'b0;
        end else begin
            state  <= state_nx;
            ss_q   <= ss_s;
            sclk_q <= sclk_s;
        end
    end

    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        abort     = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    start    = 1'b1;
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    do_sample = sample;
                    do_shift  = shift;
                    if (sample && cnt == CW'(DW - 1)) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                finish   = 1'b1;
                state_nx = ss_rise ? IDLE : WAIT;
            end
            WAIT: begin
                if (ss_rise) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol        <= 1'b0;
            cpha        <= 1'b0;
            hold        <= '0;
            hold_full   <= 1'b0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            cnt         <= '0;
            miso_r      <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid    <= finish;
            tx_underrun <= start & ~hold_full;
            frame_err   <= abort;
            if (start) begin
                cpol      <= spi_mode[CPOL];
                cpha      <= spi_mode[CPHA];
                cnt       <= '0;
                tx_sh     <= hold_full ? hold : '0;
                miso_r    <= hold_full & hold[DW-1];
                hold_full <= 1'b0;
            end
            // only reachable while empty, so a same-cycle start underruns
            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
            if (do_shift) begin
                miso_r <= cpha ? tx_sh[DW-1] : tx_sh[DW-2];
                tx_sh  <= {tx_sh[DW-2:0], 1'b0};
            end
            if (do_sample) begin
                rx_sh <= {rx_sh[DW-2:0], mosi_s};
                cnt   <= cnt + CW'(1);
            end
            if (finish) begin
                rx_data <= rx_sh;
            end
            if (state != IDLE && state_nx == IDLE) begin
                miso_r <= 1'b0;
            end
        end
    end

    assign miso     = miso_r;
    assign miso_oe  = (state != IDLE);
    assign tx_ready = ~hold_full;

endmodule
